// File: rtl/counter_incr_batcher_pkg.sv
// Shared helpers for the increment batcher: per-cycle output limit, adder-tree width,
// and the default backlog word type.
package counter_incr_batcher_pkg;

  localparam int DEFAULT_BACKLOG_BITS = 24;

  typedef logic [DEFAULT_BACKLOG_BITS-1:0] t_backlog;

  // Largest legal per-cycle increment for a split counter of num_bits: 2^(num_bits/2)-1.
  function automatic logic [63:0] max_out(input int num_bits);
    return (64'd1 << (num_bits / 2)) - 64'd1;
  endfunction

  // Width needed to hold the sum of n_src values of in_bits each.
  function automatic int sum_bits(input int n_src, input int in_bits);
    return $clog2(n_src) + in_bits;
  endfunction

endpackage

// File: rtl/counter_incr_batcher_if.sv
// Source-side and counter-side signal bundle of the increment batcher.
interface counter_incr_batcher_if #(
  parameter int NUM_BITS     = 64,
  parameter int N_SRC        = 4,
  parameter int IN_BITS      = 16,
  parameter int BACKLOG_BITS = 24
);

  logic [N_SRC-1:0]              in_valid;
  logic [N_SRC-1:0][IN_BITS-1:0] in_incr;
  logic [NUM_BITS-1:0]           incr_by;
  logic                          backlog_pending;
  logic                          overflow_err;
  logic [BACKLOG_BITS-1:0]       peak_backlog;

  modport master (
    output in_valid,
    output in_incr,
    input  incr_by,
    input  backlog_pending,
    input  overflow_err,
    input  peak_backlog
  );

  modport slave (
    input  in_valid,
    input  in_incr,
    output incr_by,
    output backlog_pending,
    output overflow_err,
    output peak_backlog
  );

endinterface

// File: rtl/counter_incr_sum_tree.sv
// Stages 1-2 of the batcher: registered valid-gating of every source, then a
// registered single-level sum. Swap for a deeper tree if the adder limits timing.
module counter_incr_sum_tree #(
  parameter int N_SRC    = 4,
  parameter int IN_BITS  = 16,
  parameter int SUM_BITS = 18
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [N_SRC-1:0]              in_valid,
  input  logic [N_SRC-1:0][IN_BITS-1:0] in_incr,
  output logic [SUM_BITS-1:0]           sum_q
);

  logic [IN_BITS-1:0]  gated_reg [N_SRC];
  logic [SUM_BITS-1:0] sum_next;
  logic [SUM_BITS-1:0] sum_reg;

  generate
    for (genvar gi = 0; gi < N_SRC; gi++) begin : g_gate
      always_ff @(posedge clk) begin
        if (reset) begin
          gated_reg[gi] <= '0;
        end else begin
          gated_reg[gi] <= in_valid[gi] ? in_incr[gi] : '0;
        end
      end
    end
  endgenerate

  always_comb begin
    sum_next = '0;
    for (int i = 0; i < N_SRC; i++) begin
      sum_next = sum_next + SUM_BITS'(gated_reg[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sum_reg <= '0;
    end else begin
      sum_reg <= sum_next;
    end
  end

  assign sum_q = sum_reg;

endmodule

// File: rtl/counter_incr_batcher.sv
// Merges N_SRC increment streams into one per-cycle increment no larger than
// 2^(NUM_BITS/2)-1, spilling the excess into a draining backlog. Optional peak
// backlog tracking is built when COUNTER_INCR_BATCHER_PEAK_EN is defined.
module counter_incr_batcher
  import counter_incr_batcher_pkg::*;
#(
  parameter int NUM_BITS     = 64,
  parameter int N_SRC        = 4,
  parameter int IN_BITS      = 16,
  parameter int BACKLOG_BITS = 24
) (
  input  logic                   clk,
  input  logic                   reset,
  counter_incr_batcher_if.slave  bus
);

  localparam int SUM_BITS   = sum_bits(N_SRC, IN_BITS);
  localparam int TOTAL_BITS = BACKLOG_BITS + 1;
  localparam int HALF_BITS  = NUM_BITS / 2;
  // Comparison width wide enough for both the stage-3 total and the output limit.
  localparam int CMP_BITS   = (TOTAL_BITS > HALF_BITS) ? TOTAL_BITS : HALF_BITS;

  localparam logic [CMP_BITS-1:0] MAX_OUT_EXT     = CMP_BITS'(max_out(NUM_BITS));
  localparam logic [CMP_BITS-1:0] BACKLOG_MAX_EXT = CMP_BITS'({BACKLOG_BITS{1'b1}});

  typedef logic [BACKLOG_BITS-1:0] t_backlog_p;

  generate
    if (NUM_BITS % 2 != 0) begin : g_bad_num_bits
      $fatal(1, "counter_incr_batcher: NUM_BITS must be even");
    end
    if (SUM_BITS > BACKLOG_BITS) begin : g_bad_backlog_bits
      $fatal(1, "counter_incr_batcher: IN_BITS + clog2(N_SRC) exceeds BACKLOG_BITS");
    end
  endgenerate

  logic [SUM_BITS-1:0]   sum_q;
  logic [TOTAL_BITS-1:0] total;
  logic [CMP_BITS-1:0]   total_ext;
  logic [CMP_BITS-1:0]   out_ext;
  logic [CMP_BITS-1:0]   rem_ext;
  logic                  sat_next;
  t_backlog_p            backlog_next;

  t_backlog_p            backlog_reg;
  logic [NUM_BITS-1:0]   incr_by_reg;
  logic                  backlog_pending_reg;
  logic                  overflow_err_reg;

  counter_incr_sum_tree #(
    .N_SRC    (N_SRC),
    .IN_BITS  (IN_BITS),
    .SUM_BITS (SUM_BITS)
  ) u_sum_tree (
    .clk      (clk),
    .reset    (reset),
    .in_valid (bus.in_valid),
    .in_incr  (bus.in_incr),
    .sum_q    (sum_q)
  );

  // Stage 3: fresh sum and backlog drain share one adder, so input never stalls.
  always_comb begin
    total        = TOTAL_BITS'(sum_q) + TOTAL_BITS'(backlog_reg);
    total_ext    = CMP_BITS'(total);
    out_ext      = (total_ext > MAX_OUT_EXT) ? MAX_OUT_EXT : total_ext;
    rem_ext      = total_ext - out_ext;
    sat_next     = (rem_ext > BACKLOG_MAX_EXT);
    backlog_next = sat_next ? '1 : t_backlog_p'(rem_ext);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      backlog_reg         <= '0;
      incr_by_reg         <= '0;
      backlog_pending_reg <= 1'b0;
      overflow_err_reg    <= 1'b0;
    end else begin
      backlog_reg         <= backlog_next;
      incr_by_reg         <= NUM_BITS'(out_ext);
      backlog_pending_reg <= (backlog_next != '0);
      if (sat_next) begin
        overflow_err_reg <= 1'b1;
      end
    end
  end

  assign bus.incr_by         = incr_by_reg;
  assign bus.backlog_pending = backlog_pending_reg;
  assign bus.overflow_err    = overflow_err_reg;

`ifdef COUNTER_INCR_BATCHER_PEAK_EN
  t_backlog_p peak_reg;

  // Follows the registered backlog, so the peak trails a new maximum by one cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      peak_reg <= '0;
    end else if (backlog_reg > peak_reg) begin
      peak_reg <= backlog_reg;
    end
  end

  assign bus.peak_backlog = peak_reg;
`else
  assign bus.peak_backlog = '0;
`endif

endmodule

// File: tb/tb_counter_incr_batcher.sv
// Self-checking bench for counter_incr_batcher (NUM_BITS=16, N_SRC=4, IN_BITS=8,
// BACKLOG_BITS=12): vector table, directed corner sequences, randomized scoreboard.
module tb_counter_incr_batcher;

  localparam int NUM_BITS     = 16;
  localparam int N_SRC        = 4;
  localparam int IN_BITS      = 8;
  localparam int BACKLOG_BITS = 12;
  localparam longint LIMIT    = 255;
  localparam longint BL_MAX   = 4095;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  counter_incr_batcher_if #(
    .NUM_BITS(NUM_BITS), .N_SRC(N_SRC), .IN_BITS(IN_BITS), .BACKLOG_BITS(BACKLOG_BITS)
  ) bus_if ();

  counter_incr_batcher #(
    .NUM_BITS(NUM_BITS), .N_SRC(N_SRC), .IN_BITS(IN_BITS), .BACKLOG_BITS(BACKLOG_BITS)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference: per-edge input totals reach the output stage two edges later.
  longint pipe[$];
  longint m_backlog, m_peak, m_out;
  bit     m_ovf;
  longint in_acc, out_acc;

  typedef struct packed {
    logic [3:0]      valid;
    logic [3:0][7:0] incr;
    int              first;
    int              pend;
    int              total;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    pipe.delete();
    pipe.push_back(0);
    pipe.push_back(0);
    m_backlog = 0;
    m_peak    = 0;
    m_out     = 0;
    m_ovf     = 1'b0;
  endtask

  task automatic drive(input logic [3:0] v, input logic [3:0][7:0] x);
    bus_if.in_valid = v;
    bus_if.in_incr  = x;
  endtask

  // One clock edge: advance the model with the inputs now applied, then compare.
  task automatic tick();
    longint s = 0;
    longint arrived, tot, rem;
    for (int i = 0; i < N_SRC; i++) begin
      if (bus_if.in_valid[i]) s += longint'(bus_if.in_incr[i]);
    end
    if (reset) begin
      model_reset();
    end else begin
      in_acc += s;
      pipe.push_back(s);
      arrived = pipe.pop_front();
      tot     = arrived + m_backlog;
      if (m_backlog > m_peak) m_peak = m_backlog;
      m_out   = (tot > LIMIT) ? LIMIT : tot;
      rem     = tot - m_out;
      if (rem > BL_MAX) begin
        m_backlog = BL_MAX;
        m_ovf     = 1'b1;
      end else begin
        m_backlog = rem;
      end
    end
    @(posedge clk);
    #1;
    out_acc += longint'(bus_if.incr_by);
    check("incr_by", longint'(bus_if.incr_by), m_out);
    check("upper_half_zero", longint'(bus_if.incr_by[15:8]), 0);
    check("backlog_pending", longint'(bus_if.backlog_pending), (m_backlog != 0) ? 1 : 0);
    check("overflow_err", longint'(bus_if.overflow_err), m_ovf ? 1 : 0);
`ifdef COUNTER_INCR_BATCHER_PEAK_EN
    check("peak_backlog", longint'(bus_if.peak_backlog), m_peak);
`else
    check("peak_backlog", longint'(bus_if.peak_backlog), 0);
`endif
  endtask

  initial begin
    longint sm;
    int pc;
    logic [3:0] rv;
    logic [3:0][7:0] rx;

    // {valid, {src3,src2,src1,src0}, first output, cycles pending, total out}
    vecs[0] = '{4'b0001, {8'd0,   8'd0,   8'd0,   8'd10},  10,  0, 10};
    vecs[1] = '{4'b1111, {8'd200, 8'd200, 8'd200, 8'd200}, 255, 3, 800};
    vecs[2] = '{4'b0000, {8'd255, 8'd255, 8'd255, 8'd255}, 0,   0, 0};
    vecs[3] = '{4'b1010, {8'd40,  8'd30,  8'd20,  8'd10},  60,  0, 60};
    vecs[4] = '{4'b1111, {8'd1,   8'd0,   8'd255, 8'd255}, 255, 2, 511};
    vecs[5] = '{4'b0111, {8'd99,  8'd55,  8'd100, 8'd100}, 255, 0, 255};
    vecs[6] = '{4'b1111, {8'd64,  8'd64,  8'd64,  8'd64},  255, 1, 256};

    in_acc  = 0;
    out_acc = 0;
    model_reset();
    drive('0, '0);
    reset = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    check("reset_incr_by", longint'(bus_if.incr_by), 0);
    check("reset_pending", longint'(bus_if.backlog_pending), 0);
    check("reset_overflow", longint'(bus_if.overflow_err), 0);
    check("reset_peak", longint'(bus_if.peak_backlog), 0);
    $display("reset: incr_by=%0d pending=%0d ovf=%0d", bus_if.incr_by,
             bus_if.backlog_pending, bus_if.overflow_err);
    tick();

    // Single-cycle bursts: input sampled at edge k, first output after edge k+2.
    for (int v = 0; v < 7; v++) begin
      drive(vecs[v].valid, vecs[v].incr);
      tick();
      drive('0, '0);
      tick();
      check("latency_early_zero", longint'(bus_if.incr_by), 0);
      tick();
      check("first_output", longint'(bus_if.incr_by), vecs[v].first);
      sm = longint'(bus_if.incr_by);
      pc = int'(bus_if.backlog_pending);
      for (int c = 0; c < 6; c++) begin
        tick();
        sm += longint'(bus_if.incr_by);
        pc += int'(bus_if.backlog_pending);
      end
      check("burst_total", sm, vecs[v].total);
      check("pending_cycles", pc, vecs[v].pend);
      $display("vec %0d: valid=%b first=%0d total=%0d pending_cycles=%0d",
               v, vecs[v].valid, vecs[v].first, sm, pc);
    end

    // Reset with backlog 500 and two increments still in the sum tree.
    drive(4'b1111, {8'd155, 8'd200, 8'd200, 8'd200});
    tick();
    drive(4'b0001, {8'd0, 8'd0, 8'd0, 8'd10});
    tick();
    drive(4'b0001, {8'd0, 8'd0, 8'd0, 8'd20});
    tick();
    check("pre_reset_pending", longint'(bus_if.backlog_pending), 1);
    check("pre_reset_incr_by", longint'(bus_if.incr_by), 255);
    drive('0, '0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("midflight_incr_by", longint'(bus_if.incr_by), 0);
    check("midflight_pending", longint'(bus_if.backlog_pending), 0);
    check("midflight_overflow", longint'(bus_if.overflow_err), 0);
    sm = 0;
    for (int c = 0; c < 6; c++) begin
      tick();
      sm += longint'(bus_if.incr_by);
    end
    check("midflight_residual", sm, 0);
    $display("midflight reset: residual output=%0d", sm);

    // Continuous 1020/cycle: backlog +765 per output cycle, saturates on the 6th.
    drive(4'b1111, {8'd255, 8'd255, 8'd255, 8'd255});
    for (int c = 0; c < 10; c++) begin
      tick();
      check("sat_incr_by", longint'(bus_if.incr_by), (c >= 2) ? 255 : 0);
      check("sat_overflow", longint'(bus_if.overflow_err), (c >= 7) ? 1 : 0);
    end
    drive('0, '0);
    repeat (30) tick();
    check("overflow_sticky", longint'(bus_if.overflow_err), 1);
    $display("saturation: overflow_err=%0d after drain", bus_if.overflow_err);
    reset = 1'b1;
    repeat (2) tick();
    reset = 1'b0;
    check("overflow_cleared", longint'(bus_if.overflow_err), 0);

    // Peak tracking: 800 burst (backlog 545), drain, then 300 (backlog 45).
    drive(4'b1111, {8'd200, 8'd200, 8'd200, 8'd200});
    tick();
    drive('0, '0);
    repeat (8) tick();
    drive(4'b0011, {8'd0, 8'd0, 8'd150, 8'd150});
    tick();
    drive('0, '0);
    repeat (8) tick();
`ifdef COUNTER_INCR_BATCHER_PEAK_EN
    check("peak_after_bursts", longint'(bus_if.peak_backlog), 545);
`else
    check("peak_after_bursts", longint'(bus_if.peak_backlog), 0);
`endif
    $display("peak: peak_backlog=%0d", bus_if.peak_backlog);

    // Randomized traffic with a conservation scoreboard.
    reset = 1'b1;
    repeat (2) tick();
    reset = 1'b0;
    in_acc  = 0;
    out_acc = 0;
    for (int c = 0; c < 10000; c++) begin
      for (int i = 0; i < N_SRC; i++) begin
        rv[i] = ($urandom_range(0, 3) == 0);
        rx[i] = 8'($urandom_range(0, 255));
      end
      drive(rv, rx);
      tick();
    end
    drive('0, '0);
    repeat (40) tick();
    check("conservation", out_acc, in_acc);
    check("random_no_overflow", longint'(bus_if.overflow_err), 0);
    check("random_drained", longint'(bus_if.backlog_pending), 0);
    $display("random: in_sum=%0d out_sum=%0d", in_acc, out_acc);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
